// File: rtl/selector_botones.sv
// Debounced push-button selector with auto-repeat, producing active-low
// one-cycle increment/decrement strobes for a duty-value up/down counter.
module selector_botones #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_sum_n,
    input  logic btn_rest_n,
    output logic sum,
    output logic rest
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] DEB_PRESS   = 3'd1;
    localparam logic [2:0] HELD        = 3'd2;
    localparam logic [2:0] REPEAT      = 3'd3;
    localparam logic [2:0] DEB_RELEASE = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] pulse;
    logic [1:0] in_hold;
    logic [1:0] req;
    logic       lock;

    // Bit 0 is the increment button, bit 1 the decrement button.
    assign raw  = {btn_rest_n, btn_sum_n};
    assign lock = &in_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [2:0]       state;
        logic [2:0]       prior;
        logic [CNT_W-1:0] tmr;
        logic [CNT_W-1:0] deb;
        logic             pressed;

        assign pressed    = ~sync2[i];
        assign in_hold[i] = (state == HELD) || (state == REPEAT);
        assign pulse[i]   = pressed &&
                            (((state == DEB_PRESS) && (deb == DEB_LAST))   ||
                             ((state == HELD)      && (tmr == DELAY_LAST)) ||
                             ((state == REPEAT)    && (tmr == RATE_LAST)));

        // The repeat timer is frozen while a release is being debounced so a
        // short glitch resumes the cadence exactly where it left off.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state <= IDLE;
                prior <= HELD;
                tmr   <= '0;
                deb   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            state <= DEB_PRESS;
                            deb   <= '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (!pressed) begin
                            state <= IDLE;
                        end else if (deb == DEB_LAST) begin
                            state <= HELD;
                            tmr   <= '0;
                        end else begin
                            deb <= sat_inc(deb);
                        end
                    end
                    HELD, REPEAT: begin
                        if (!pressed) begin
                            state <= DEB_RELEASE;
                            prior <= state;
                            deb   <= '0;
                        end else if ((state == HELD) && (tmr == DELAY_LAST)) begin
                            state <= REPEAT;
                            tmr   <= '0;
                        end else if ((state == REPEAT) && (tmr == RATE_LAST)) begin
                            tmr <= '0;
                        end else begin
                            tmr <= sat_inc(tmr);
                        end
                    end
                    DEB_RELEASE: begin
                        if (pressed) begin
                            state <= prior;
                        end else if (deb == DEB_LAST) begin
                            state <= IDLE;
                            tmr   <= '0;
                        end else begin
                            deb <= sat_inc(deb);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Requests are registered once, then arbitrated so both strobes never coincide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req  <= 2'b00;
            sum  <= 1'b1;
            rest <= 1'b1;
        end else begin
            req  <= lock ? 2'b00 : pulse;
            sum  <= ~(req[0] & ~req[1]);
            rest <= ~(req[1] & ~req[0]);
        end
    end

endmodule

// File: doc/selector_botones.md
SELECTOR_BOTONES -- requirements
Module: selector_botones

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized samples required to accept a press or release.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 64, meaning cycles from the first pulse to the first auto-repeat pulse while held.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 16, meaning cycles between auto-repeat pulses after the first repeat.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of the internal timers; all three timing parameters are in the range 1..2**CNT_W-1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port btn_sum_n, input, 1 bit: raw asynchronous "increment" push-button, low = pressed.
REQ-008 The block SHALL have port btn_rest_n, input, 1 bit: raw asynchronous "decrement" push-button, low = pressed.
REQ-009 The block SHALL have port sum, output, 1 bit: registered active-low one-cycle increment strobe for the duty-value up/down counter.
REQ-010 The block SHALL have port rest, output, 1 bit: registered active-low one-cycle decrement strobe for the same counter.

Function
REQ-011 Each raw button SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-012 Each button SHALL have an independent FSM with states IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE.
REQ-013 IDLE: a synchronized low SHALL move the FSM to DEB_PRESS with its timer cleared.
REQ-014 DEB_PRESS: after DEBOUNCE_CYCLES consecutive synchronized-low samples the FSM SHALL enter HELD and request one pulse; any high sample SHALL return it to IDLE.
REQ-015 HELD: after REPEAT_DELAY cycles still low the FSM SHALL enter REPEAT and request one pulse; a synchronized high SHALL move it to DEB_RELEASE.
REQ-016 REPEAT: the FSM SHALL request one pulse every REPEAT_RATE cycles while low; a synchronized high SHALL move it to DEB_RELEASE.
REQ-017 DEB_RELEASE: after DEBOUNCE_CYCLES consecutive high samples the FSM SHALL return to IDLE; any low sample SHALL return it to its prior HELD or REPEAT state, keeping the timer value and issuing no new pulse.
REQ-018 A pulse request SHALL drive the matching output low for exactly one cycle, registered, on the clock edge after the request.
REQ-019 Press latency SHALL be fixed: a raw low first sampled at edge 0 and held stable SHALL make the output low in the cycle following edge DEBOUNCE_CYCLES+3.
REQ-020 If both FSMs request a pulse in the same cycle, both requests SHALL be dropped, so sum and rest are never low in the same cycle.
REQ-021 While both FSMs are in HELD or REPEAT, all pulse requests SHALL be suppressed (lockout); timers keep running, and pulses resume when one button reaches DEB_RELEASE.
REQ-022 Timers SHALL saturate and never wrap; every comparison SHALL be at CNT_W width.
REQ-023 Outputs SHALL be high in every cycle without a granted request; no glitches, all outputs are direct flop outputs.

Reset
REQ-024 With rst low at a rising edge, both synchronizers SHALL load 1, both FSMs SHALL go to IDLE, all timers SHALL clear, and sum=1 and rest=1 on the next cycle.
REQ-025 Reset asserted mid-press or mid-repeat SHALL abort with no further pulse; after release, a button still held SHALL be re-debounced from IDLE.

Verification
(All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.)
REQ-026 Clean press: btn_sum_n low at edge 0, held for 8 cycles, then high -> sum low only in the cycle after edge 7; rest stays 1.
REQ-027 Bounce: btn_rest_n toggles low 2 cycles, high 1, low 2, high -> no pulse; a following stable 6-cycle low -> exactly one rest pulse.
REQ-028 Auto-repeat: btn_sum_n held low for 40 cycles -> first pulse at cycle 8, then pulses at cycles 18, 21, 24, 27, 30, 33, 36, 39; exactly one cycle each.
REQ-029 Simultaneous: both buttons fall on the same edge and are held for 30 cycles -> sum and rest stay 1 throughout; after releasing btn_rest_n, sum pulses resume.
REQ-030 Release glitch: during REPEAT, btn_sum_n goes high 2 cycles then low -> no extra pulse, and the repeat cadence continues from the preserved timer.
REQ-031 Reset mid-repeat: rst low for 1 cycle during REPEAT with btn_sum_n held -> sum=1 after reset; the next pulse comes DEBOUNCE_CYCLES+3 cycles after rst returns high.
